bit_serial_adder: RTL and testbench
===================================

# bit_serial_adder

Bit-serial modular adder that computes a + b + cin over WIDTH bits, one bit per clock, through a single full-adder cell and a registered carry. It is the sequencing stage that wraps the 1-bit full adder into word-level additions for the hashing datapath, such as SHA-256 mod-2^32 additions, trading throughput for area. Operands arrive on a valid/ready input port, and results leave on a valid/ready output port.

## Interface
- WIDTH, 32, operand and result width in bits; legal values ≥ 2.
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand word present on a, b, cin.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  operand A, sampled only on the accept edge.
- b  input  WIDTH  operand B, sampled only on the accept edge.
- cin  input  1  carry-in, sampled only on the accept edge.
- out_valid  output  1  sum and cout hold a completed result.
- out_ready  input  1  consumer takes the result.
- sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- busy  output  1  high in RUN and DONE.

One clock; reset is asynchronous and active-low.

## Operation
- State machine has three states, IDLE, RUN and DONE, and enters IDLE on reset.
- **IDLE:** in_ready=1.
  - On in_valid & in_ready, latch a and b into shift registers sa and sb, load carry ← cin, load bit counter ← 0, go to RUN.
- **RUN:** each cycle processes the LSBs of sa and sb with carry c.
  - s = sa[0] ^ sb[0] ^ c.
  - c ← (sa[0]&sb[0]) | (sb[0]&c) | (sa[0]&c).
  - sa and sb shift right by 1.
  - sum register shifts right with s entering the MSB.
  - counter increments.
  - When the counter reaches WIDTH-1 and that bit has been processed, set cout ← c, set out_valid ← 1, go to DONE.
- **DONE:** sum, cout and out_valid are held stable.
  - On out_valid & out_ready, clear out_valid and go to IDLE.
  - in_ready stays 0, so an in_valid in this state is not accepted.
- Arithmetic wraps modulo 2^WIDTH. The carry beyond the top bit is reported only on cout; no overflow flag.
- sum and cout keep the last result after the return to IDLE, until the next accept.
  - During RUN, sum holds partial shift contents and is only meaningful when out_valid=1.
- The counter is ceil(log2(WIDTH)) bits wide and saturates out of RUN; it never wraps inside an operation.
- Reset mid-operation discards the operation immediately, with no out_valid pulse. The next accepted operation is unaffected.

## Timing
- While rst_n=0: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0. Shift registers, carry and counter are all 0.
- All outputs are registered, or decoded from the state register only. There is no combinational path from inputs to outputs.
- Accept edge is E0. RUN occupies the WIDTH cycles after E0, ending at edge E_WIDTH.
  - out_valid=1 in the cycle following E_WIDTH, which is cycle WIDTH+1 counting the accept cycle as 0.
- Minimum accept-to-accept spacing is WIDTH+2 cycles, with out_ready held at 1.
- The output handshake completes on any edge where out_valid & out_ready are both 1. There is no limit on how long out_ready may stay low.
- busy rises the cycle after the accept edge and falls the cycle after the output handshake.
- a, b and cin may change freely after the accept edge without affecting the result.

## Test plan
All scenarios use WIDTH=32.

1. **Reset values:** hold rst_n=0 → in_ready=1, out_valid=0, busy=0, sum=0, cout=0. Release, then idle 5 cycles → no change.
2. **Basic add:** a=0x6A09E667, b=0xBB67AE85, cin=0 → out_valid exactly 33 cycles after the accept cycle, sum=0x257194EC, cout=1.
3. **Full carry ripple:** a=0xFFFFFFFF, b=0x00000000, cin=1 → sum=0x00000000, cout=1. Then a=0x7FFFFFFF, b=0x00000001, cin=0 → sum=0x80000000, cout=0.
4. **Backpressure:** hold out_ready=0 for 6 cycles in DONE while pulsing in_valid with new operands → sum, cout and out_valid stay stable, in_ready=0, and no new operand is accepted. Raise out_ready → one handshake, then IDLE next cycle.
5. **Mid-run reset:** assert rst_n=0 after bit 10 of a RUN → out_valid stays 0, and every output shows its reset value at once. Release, then add a=1, b=2, cin=0 → sum=3, cout=0.
6. **Streaming:** tie in_valid=1 and out_ready=1 and drive 200 random (a, b, cin) vectors → accepts exactly 34 cycles apart, and every result matches a 33-bit behavioural model.

Source files
------------

// File: rtl/bit_serial_adder.sv
// ---------------------------------------------------------------------------
// bit_serial_adder
//   Word-level modular adder built from a single full-adder cell. One bit of
//   (a + b + cin) is produced per clock, LSB first, with the carry kept in a
//   flop between bits. Used by the hashing datapath for mod-2^WIDTH sums
//   where area matters more than throughput.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand word present on a, b, cin
//   in_ready   operands accepted this cycle if in_valid (IDLE only)
//   a, b       WIDTH-bit operands, captured on the accept edge
//   cin        carry-in, captured on the accept edge
//   out_valid  sum/cout hold a completed result
//   out_ready  consumer takes the result
//   sum        (a + b + cin) mod 2^WIDTH
//   cout       carry out of bit WIDTH-1
//   busy       operation in flight or result waiting (RUN or DONE)
// ---------------------------------------------------------------------------

// One-bit full adder cell; the only arithmetic in the block.
module bsa_full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (b_i & c_i) | (a_i & c_i);
endmodule

module bit_serial_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cout_q, cout_d;
    logic             out_valid_q, out_valid_d;

    logic             fa_s, fa_c;

    // The full adder always looks at the current LSBs; its result is only
    // committed while in RUN.
    bsa_full_adder u_fa (
        .a_i (sa_q[0]),
        .b_i (sb_q[0]),
        .c_i (carry_q),
        .s_o (fa_s),
        .c_o (fa_c)
    );

    always_comb begin
        state_d     = state_q;
        sa_d        = sa_q;
        sb_d        = sb_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        cout_d      = cout_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sa_d    = a;
                    sb_d    = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sa_d    = sa_q >> 1;
                sb_d    = sb_q >> 1;
                carry_d = fa_c;
                // Sum bits enter at the top; after WIDTH shifts bit 0 has
                // reached the LSB and the word is aligned.
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                if (cnt_q == LAST) begin
                    // Counter holds at LAST rather than wrapping to 0.
                    cout_d      = fa_c;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                // out_valid_q is always 1 here, so out_ready alone completes
                // the handshake.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sa_q        <= '0;
            sb_q        <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sa_q        <= sa_d;
            sb_q        <= sb_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Handshake/status outputs decode only the state register.
    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
module tb_bit_serial_adder;
    localparam int W = 32;

    logic         clk, rst_n;
    logic         in_valid, in_ready;
    logic [W-1:0] a, b;
    logic         cin;
    logic         out_valid, out_ready;
    logic [W-1:0] sum;
    logic         cout, busy;

    bit_serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    // ---------------- behavioural model + per-cycle compare ----------------
    logic [W:0] exp_q[$];
    logic [W:0] m_last    = '0;
    bit         m_active  = 0;
    int         m_acc     = 0;
    int         acc_count = 0;
    int         hs_count  = 0;
    bit         stream    = 0;
    bit         have_prev = 0;
    int         prev_acc  = 0;

    always @(negedge clk) begin
        bit e_busy, e_ov;
        if (!rst_n) begin
            m_active = 0;
            exp_q.delete();
            m_last    = '0;
            have_prev = 0;
        end
        // Cycle of accept has index m_acc; busy from the next cycle, result
        // visible WIDTH+1 cycles after the accept cycle.
        e_busy = m_active && (cyc > m_acc);
        e_ov   = m_active && (cyc >= m_acc + W + 1);
        chk("in_ready",  64'(in_ready),  64'(!e_busy));
        chk("busy",      64'(busy),      64'(e_busy));
        chk("out_valid", 64'(out_valid), 64'(e_ov));
        if (e_ov) begin
            if (exp_q.size() > 0) chk("result", 64'({cout, sum}), 64'(exp_q[0]));
        end else if (!e_busy) begin
            chk("held_result", 64'({cout, sum}), 64'(m_last));
        end
        if (rst_n && e_ov && out_ready) begin
            if (exp_q.size() > 0) m_last = exp_q.pop_front();
            m_active = 0;
            hs_count++;
        end
        if (rst_n && !e_busy && in_valid) begin
            exp_q.push_back(ref_add(a, b, cin));
            if (stream && have_prev) chk("accept_spacing", 64'(cyc - prev_acc), 64'(W + 2));
            prev_acc  = cyc;
            have_prev = 1;
            m_active  = 1;
            m_acc     = cyc;
            acc_count++;
        end
    end

    // ---------------- directed helpers ----------------
    task automatic accept_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc);
        int st = acc_count;
        bit got = 0;
        @(posedge clk); #1;
        a = ta; b = tb_; cin = tc; in_valid = 1'b1;
        for (int i = 0; i < 100 && !got; i++) begin
            @(posedge clk);
            if (acc_count != st) got = 1;
        end
        if (!got) chk("accept_timeout", 64'(0), 64'(1));
        #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; cin = 1'($urandom);
    endtask

    // Called just after the accept edge; counts edges until out_valid.
    task automatic wait_valid(output int lat);
        bit got = 0;
        lat = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            if (out_valid) got = 1;
            else begin
                @(posedge clk); #1;
                lat++;
            end
        end
        if (!got) chk("valid_timeout", 64'(0), 64'(1));
    endtask

    task automatic wait_hs();
        int st = hs_count;
        bit got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk);
            if (hs_count != st) got = 1;
        end
        if (!got) chk("handshake_timeout", 64'(0), 64'(1));
        #1;
    endtask

    task automatic run_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tc, input logic [W:0] lit);
        int lat;
        accept_op(ta, tb_, tc);
        wait_valid(lat);
        chk({nm, "_latency"}, 64'(lat), 64'(W));
        wait_hs();
        chk({nm, "_sum"},  64'(sum),  64'(lit[W-1:0]));
        chk({nm, "_cout"}, 64'(cout), 64'(lit[W]));
    endtask

    initial begin
        int lat, st;
        bit got;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0;

        // Model pinned against hand-computed sums.
        chk("model_basic",  64'(ref_add(32'h6A09E667, 32'hBB67AE85, 1'b0)), 64'h1_257194EC);
        chk("model_ripple", 64'(ref_add(32'hFFFFFFFF, 32'h0, 1'b1)),        64'h1_00000000);

        // 1. reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_sum", 64'(sum), 64'(0));
        chk("rst_cout", 64'(cout), 64'(0));
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // 2./3. directed sums
        run_op("basic",   32'h6A09E667, 32'hBB67AE85, 1'b0, 33'h1_257194EC);
        run_op("ripple1", 32'hFFFFFFFF, 32'h00000000, 1'b1, 33'h1_00000000);
        run_op("ripple2", 32'h7FFFFFFF, 32'h00000001, 1'b0, 33'h0_80000000);

        // 4. backpressure with in_valid pulsed in DONE
        out_ready = 1'b0;
        st = acc_count;
        accept_op(32'h12345678, 32'h9ABCDEF0, 1'b0);
        wait_valid(lat);
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'($urandom); a = $urandom; b = $urandom; cin = 1'($urandom);
            @(posedge clk); #1;
            chk("bp_out_valid", 64'(out_valid), 64'(1));
            chk("bp_in_ready", 64'(in_ready), 64'(0));
            chk("bp_sum", 64'(sum), 64'h ACF13568);
            chk("bp_cout", 64'(cout), 64'(0));
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_idle_ready", 64'(in_ready), 64'(1));
        chk("bp_idle_valid", 64'(out_valid), 64'(0));
        chk("bp_accepts", 64'(acc_count - st), 64'(1));

        // 5. reset after bit 10 of a run
        accept_op(32'hDEADBEEF, 32'h01234567, 1'b1);
        repeat (11) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mrst_in_ready", 64'(in_ready), 64'(1));
        chk("mrst_out_valid", 64'(out_valid), 64'(0));
        chk("mrst_busy", 64'(busy), 64'(0));
        chk("mrst_sum", 64'(sum), 64'(0));
        chk("mrst_cout", 64'(cout), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_op("post_rst", 32'd1, 32'd2, 1'b0, 33'd3);

        // 6. streaming random vectors
        stream = 1; have_prev = 0;
        st = acc_count; got = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; out_ready = 1'b1;
        a = $urandom; b = $urandom; cin = 1'($urandom);
        for (int i = 0; i < 200 * (W + 2) + 200 && !got; i++) begin
            @(posedge clk); #1;
            if (acc_count - st >= 200) begin
                got = 1;
                in_valid = 1'b0;
            end
            a = $urandom; b = $urandom; cin = 1'($urandom);
        end
        if (!got) chk("stream_timeout", 64'(0), 64'(1));
        wait_hs();
        chk("stream_accepts", 64'(acc_count - st), 64'(200));
        stream = 0;
        repeat (3) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
